pool_sequencer: RTL
===================

POOL_SEQUENCER -- requirements
Module: pool_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 8: pixels per row; even, >= 2.
REQ-002 SHALL have parameter IMG_H, default 8: rows per frame; even, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream binarized pixel valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_pix this cycle.
REQ-007 SHALL have port in_pix  input  1  binarized pixel, raster order (row-major, col 0 first); 1 = +1, 0 = -1.
REQ-008 SHALL have port out_valid  output  1  pooled pixel available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_pix.
REQ-010 SHALL have port out_pix  output  1  2x2 pooled result.
REQ-011 SHALL have port out_last  output  1  qualifies the final pooled pixel of a frame.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at the final output handshake.
REQ-013 SHALL have port busy  output  1  high whenever state != FILL or col/row counters are nonzero.

Function
REQ-014 SHALL treat an input transfer as in_valid & in_ready, and an output transfer as out_valid & out_ready.
REQ-015 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), width $clog2 each; col increments per input transfer and wraps to 0 after IMG_W-1, incrementing row.
REQ-016 SHALL have FSM states FILL (even row), POOL (odd row) and DRAIN.
REQ-017 FILL: in_ready = 1; each transfer writes in_pix into line buffer lb[col] (IMG_W bits); on the transfer at col = IMG_W-1 -> POOL.
REQ-018 POOL, even col: in_ready = 1; transfer stores in_pix in hold register h.
REQ-019 POOL, odd col: in_ready = !out_valid | out_ready; transfer loads out_pix <= lb[col-1] | lb[col] | h | in_pix and sets out_valid next cycle (latency 1 cycle).
REQ-020 POOL: on the transfer at col = IMG_W-1, go to FILL if row < IMG_H-1, otherwise to DRAIN.
REQ-021 DRAIN: in_ready = 0; -> FILL on the output transfer of the last pooled pixel, with row and col reset to 0.
REQ-022 Output register SHALL hold out_pix/out_valid/out_last stable while out_valid & !out_ready; out_valid clears after a transfer unless a new window is loaded in the same cycle (back-to-back allowed).
REQ-023 SHALL assert out_last with the pooled pixel from row IMG_H-1, col IMG_W-1; there are (IMG_W/2)*(IMG_H/2) outputs per frame.
REQ-024 SHALL pulse frame_done for exactly the cycle after the out_last output transfer.
REQ-025 in_pix SHALL be ignored when in_ready = 0; in_valid low SHALL stall the counters with no state change.
REQ-026 SHALL never drop or duplicate a pooled pixel under any out_ready pattern.

Reset
REQ-027 While rst is high: state = FILL; col = row = 0; lb = 0; h = 0; out_valid = out_pix = out_last = frame_done = 0; busy = 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first transfer after rst deasserts is treated as row 0, col 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-030 IMG_W = IMG_H = 4, all-zero frame with out_ready = 1 -> 4 outputs, all out_pix = 0; out_last on the 4th; frame_done pulses once.
REQ-031 Single 1 at row 2, col 1, rest 0 -> outputs 0,0,1,0 in order.
REQ-032 Stream a frame with out_ready held 0 in POOL -> in_ready drops at the first odd col after out_valid; output holds stable; no loss after out_ready = 1.
REQ-033 Two frames back-to-back with continuous in_valid -> 8 outputs, out_last at outputs 4 and 8; FILL re-entered after DRAIN; second frame unaffected by the first's lb contents.
REQ-034 Assert rst after 5 input transfers -> all outputs zero; the next full frame produces correct results from row 0.
REQ-035 Random in_valid/out_ready, random pixels, IMG_W = 8, IMG_H = 6 -> output stream matches the reference-model OR-of-2x2 exactly, 12 outputs.

Source files
------------

// File: rtl/pool_sequencer.sv
// 2x2 OR-pooling sequencer for a binarized raster stream: even rows are buffered,
// odd rows are combined with the buffer to emit one pooled pixel per 2x2 window.
module pool_sequencer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_pix,
  output logic out_valid,
  input  logic out_ready,
  output logic out_pix,
  output logic out_last,
  output logic frame_done,
  output logic busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  typedef enum logic [1:0] {FILL, POOL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [IMG_W-1:0] lb_q, lb_d;
  logic             h_q, h_d;
  logic             out_valid_q, out_valid_d;
  logic             out_pix_q, out_pix_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;

  logic          in_xfer, out_xfer, load, col_last, row_last;
  logic [CW-1:0] col_pair;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      FILL:    in_ready = 1'b1;
      POOL:    in_ready = col_q[0] ? (!out_valid_q || out_ready) : 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    lb_d         = lb_q;
    h_d          = h_q;
    out_valid_d  = out_valid_q;
    out_pix_d    = out_pix_q;
    out_last_d   = out_last_q;
    load         = 1'b0;
    in_xfer      = in_valid && in_ready;
    out_xfer     = out_valid_q && out_ready;
    col_last     = (col_q == COL_LAST);
    row_last     = (row_q == ROW_LAST);
    col_pair     = col_q & ~COL_ONE;
    frame_done_d = out_xfer && out_last_q;

    case (state_q)
      FILL: begin
        if (in_xfer) begin
          lb_d[col_q] = in_pix;
          if (col_last) state_d = POOL;
        end
      end
      POOL: begin
        if (in_xfer) begin
          if (col_q[0]) load = 1'b1;
          else          h_d  = in_pix;
          if (col_last) state_d = row_last ? DRAIN : FILL;
        end
      end
      default: begin
        if (out_xfer && out_last_q) begin
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
    endcase

    // Row wraps at frame end already; DRAIN only waits for the final handshake.
    if (in_xfer) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_pix_d   = lb_q[col_pair] | lb_q[col_q] | h_q | in_pix;
      out_last_d  = row_last && col_last;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      lb_q         <= '0;
      h_q          <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pix_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lb_q         <= lb_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_pix_q    <= out_pix_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    out_valid  = out_valid_q;
    out_pix    = out_pix_q;
    out_last   = out_last_q;
    frame_done = frame_done_q;
    busy       = (state_q != FILL) || (col_q != '0) || (row_q != '0);
  end

endmodule
